key_event_ctrl: RTL

//  Avalon-MM slave that debounces and sequences the board push-keys for the Nios II CPU.
//  Raw keys pass through a per-bit synchronizer and debounce FSM, then through press-edge capture and a maskable IRQ.

---
 rtl/key_event_pkg.sv | 15 +
 rtl/key_debounce.sv | 71 +++++++
 rtl/key_event_ctrl.sv | 79 +++++++
 3 files changed

// File: rtl/key_event_pkg.sv
// Shared definitions for the key event controller: register map and per-bit
// debounce FSM state encoding.
package key_event_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_DEBOUNCE = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK  = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } deb_state_e;

endpackage

// File: rtl/key_debounce.sv
// One key bit: 2-flop synchronizer, debounce FSM with saturating counter, and
// a one-cycle press pulse on a debounced transition away from the idle level.
module key_debounce
  import key_event_pkg::*;
#(
  parameter int   CNT_W   = 16,
  parameter logic RST_VAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw,
  input  logic [CNT_W-1:0] threshold,
  output logic             deb,
  output logic             press_pulse
);

  logic             sync_meta;
  logic             sync;
  deb_state_e       state;
  deb_state_e       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] seen;
  logic             deb_next;
  logic             commit;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= RST_VAL;
      sync      <= RST_VAL;
      state     <= IDLE;
      cnt       <= '0;
      deb       <= RST_VAL;
    end else begin
      sync_meta <= raw;
      sync      <= sync_meta;
      state     <= state_next;
      cnt       <= cnt_next;
      deb       <= deb_next;
    end
  end

  // Cycles the mismatch has persisted including this one; cnt is 0 in IDLE,
  // so a mismatch seen in IDLE counts as 1.
  assign seen = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    deb_next   = deb;
    commit     = 1'b0;
    if (sync == deb) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else if (seen >= threshold) begin
      commit     = 1'b1;
      deb_next   = sync;
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      state_next = COUNT;
      cnt_next   = seen;
    end
  end

  assign press_pulse = commit & (sync != RST_VAL);

endmodule

// File: rtl/key_event_ctrl.sv
// Avalon-MM key controller: per-bit debounce, press-edge capture with W1C,
// maskable level IRQ and a PIO-style register map with a debounce threshold.
module key_event_ctrl
  import key_event_pkg::*;
#(
  parameter int          WIDTH      = 2,
  parameter int          CNT_W      = 16,
  parameter int unsigned DEB_RESET  = 50000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [CNT_W-1:0] threshold;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd_mux;
  logic             wr;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    key_debounce #(
      .CNT_W   (CNT_W),
      .RST_VAL (1'(ACTIVE_LOW))
    ) u_debounce (
      .clk         (clk),
      .reset       (reset),
      .raw         (in_port[i]),
      .threshold   (threshold),
      .deb         (deb[i]),
      .press_pulse (press[i])
    );
  end

  assign wr  = chipselect & ~write_n;
  assign clr = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:     rd_mux = 32'(deb);
      ADDR_DEBOUNCE: rd_mux = 32'(threshold);
      ADDR_IRQMASK:  rd_mux = 32'(irqmask);
      ADDR_EDGECAP:  rd_mux = 32'(edgecap);
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      threshold <= CNT_W'(DEB_RESET);
      irqmask   <= '0;
      edgecap   <= '0;
      readdata  <= '0;
    end else begin
      if (wr && address == ADDR_DEBOUNCE) threshold <= writedata[CNT_W-1:0];
      if (wr && address == ADDR_IRQMASK)  irqmask   <= writedata[WIDTH-1:0];
      // A press on the same edge as a clear of that bit survives.
      edgecap  <= (edgecap & ~clr) | press;
      readdata <= rd_mux;
    end
  end

  assign irq = |(edgecap & irqmask);

  assign unused_wdata = &{1'b0, writedata};

endmodule
